// File: rtl/sdp_pkg.sv
// rtl/sdp_pkg.sv - shared width, latency, op encoding and reset constants for the SDP datapath
package sdp_pkg;

  localparam int SDP_W   = 8;
  localparam int SDP_LAT = 3;

  // Op code is {ctl_1, ctl_2}: bit 1 selects add/sub, bit 0 selects multiply/xor.
  typedef enum logic [1:0] {
    SUB_XOR = 2'b00,
    SUB_MUL = 2'b01,
    ADD_XOR = 2'b10,
    ADD_MAC = 2'b11
  } op_t;

  localparam logic [SDP_W-1:0] SDP_OUT_RST = '0;

endpackage

// File: rtl/sdp_pipe_stage.sv
// rtl/sdp_pipe_stage.sv - generic valid/data pipeline register with collapsing bubbles
module sdp_pipe_stage #(
  parameter int            DW      = 8,
  parameter logic [DW-1:0] RST_VAL = '0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          up_valid,
  input  logic [DW-1:0] up_data,
  input  logic          down_adv,
  output logic          valid,
  output logic [DW-1:0] data,
  output logic          adv
);

  logic          valid_q, valid_d;
  logic [DW-1:0] data_q, data_d;

  // An empty stage always advances, so bubbles are squeezed out under backpressure.
  assign adv = !valid_q || down_adv;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (adv) begin
      valid_d = up_valid;
      // Data only moves with a real tuple so the output holds its last value when drained.
      if (up_valid) begin
        data_d = up_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= RST_VAL;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid = valid_q;
  assign data  = data_q;

endmodule

// File: rtl/sdp_pipe_impl.sv
// rtl/sdp_pipe_impl.sv - 3-stage valid/ready SDP pipeline; SDP_PIPE_PARITY_EN adds registered i_par
module sdp_pipe_impl
  import sdp_pkg::*;
#(
  parameter int W = SDP_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         ctl_1,
  input  logic         ctl_2,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] i_out
`ifdef SDP_PIPE_PARITY_EN
  ,
  output logic         i_par
`endif
);

  localparam int S1W = 2 * W + 2;
  localparam int S2W = W + 2;
`ifdef SDP_PIPE_PARITY_EN
  localparam int             S3W  = W + 1;
  localparam logic [S3W-1:0] S3RST = {1'b0, W'(SDP_OUT_RST)};
`else
  localparam int             S3W  = W;
  localparam logic [S3W-1:0] S3RST = W'(SDP_OUT_RST);
`endif

  logic           v1, v2, v3;
  logic           adv1, adv2, adv3;
  op_t            in_op, op1, op2;
  logic [W-1:0]   t1_d, t1_q, c1_q;
  logic [W-1:0]   t2_d, t2_q;
  logic [W-1:0]   acc_q, acc_d, res_d;
  logic [S1W-1:0] s1_in, s1_q;
  logic [S2W-1:0] s2_in, s2_q;
  logic [S3W-1:0] s3_in, s3_q;
  logic           cap3;

  // Stage 1: select add/sub.
  assign in_op = op_t'({ctl_1, ctl_2});
  assign t1_d  = ctl_1 ? (a + b) : (a - b);
  assign s1_in = {t1_d, c, in_op};

  sdp_pipe_stage #(.DW(S1W), .RST_VAL('0)) u_stage1 (
    .clk      (clk),
    .reset    (reset),
    .up_valid (in_valid),
    .up_data  (s1_in),
    .down_adv (adv2),
    .valid    (v1),
    .data     (s1_q),
    .adv      (adv1)
  );

  assign {t1_q, c1_q} = s1_q[S1W-1:2];
  assign op1          = op_t'(s1_q[1:0]);

  // Stage 2: multiply (low W bits) or xor.
  assign t2_d  = op1[0] ? (t1_q * c1_q) : (t1_q ^ c1_q);
  assign s2_in = {t2_d, op1};

  sdp_pipe_stage #(.DW(S2W), .RST_VAL('0)) u_stage2 (
    .clk      (clk),
    .reset    (reset),
    .up_valid (v1),
    .up_data  (s2_in),
    .down_adv (adv3),
    .valid    (v2),
    .data     (s2_q),
    .adv      (adv2)
  );

  assign t2_q = s2_q[S2W-1:2];
  assign op2  = op_t'(s2_q[1:0]);

  // Stage 3: accumulate only on the edge that actually captures a MAC tuple.
  assign cap3 = adv3 && v2;

  always_comb begin
    acc_d = acc_q;
    res_d = t2_q;
    if (op2 == ADD_MAC) begin
      res_d = acc_q + t2_q;
      if (cap3) begin
        acc_d = res_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

`ifdef SDP_PIPE_PARITY_EN
  assign s3_in = {^res_d, res_d};
`else
  assign s3_in = res_d;
`endif

  sdp_pipe_stage #(.DW(S3W), .RST_VAL(S3RST)) u_stage3 (
    .clk      (clk),
    .reset    (reset),
    .up_valid (v2),
    .up_data  (s3_in),
    .down_adv (out_ready),
    .valid    (v3),
    .data     (s3_q),
    .adv      (adv3)
  );

  assign in_ready  = adv1;
  assign out_valid = v3;
  assign i_out     = s3_q[W-1:0];
`ifdef SDP_PIPE_PARITY_EN
  assign i_par     = s3_q[W];
`endif

endmodule

// File: doc/sdp_pipe_impl.md
Name: sdp_pipe_impl

Overview:
- 3-stage pipelined implementation of the small-datapath (SDP) function: a select-add/sub stage, a multiply/xor stage, and an output/accumulate stage.
- Adds valid/ready flow control so stalls can be exercised.
- Feeds the equivalence harness as the implementation side.
- With no stalls its result equals the single-cycle spec result delayed by exactly 3 cycles.

Parameters:
W, 8, datapath width in bits for a, b, c and the result; all arithmetic is mod 2^W.

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
in_valid  input  1  operand tuple valid
in_ready  output  1  block accepts a tuple this cycle
ctl_1  input  1  1: add, 0: subtract
ctl_2  input  1  1: multiply, 0: xor
a  input  W  operand A
b  input  W  operand B
c  input  W  operand C
out_valid  output  1  result valid
out_ready  input  1  consumer accepts the result
i_out  output  W  result

Behaviour:
- Clock, reset: clock clk; reset reset, synchronous, active-high.
- Reset state: v1, v2, v3 = 0, acc = 0, i_out = 0, out_valid = 0. in_ready = 1 in the first cycle after reset.
- A tuple is accepted on in_valid && in_ready.
- Stage 1 registers t1 = ctl_1 ? a+b : a-b (W bits, wrap), plus c, ctl_1 and ctl_2.
- Stage 2 registers t2 = ctl_2 ? (t1*c)[W-1:0] : t1^c, plus the op bits.
- Stage 3 (output register):
  - If ctl_1 && ctl_2 (accumulate op): acc_next = acc + t2 (wrap); acc <= acc_next; i_out <= acc_next.
  - Otherwise: i_out <= t2 and acc is unchanged.
- acc updates only in the cycle stage 3 captures an accumulate op, never on stall cycles.
- Flow control, per stage k:
  - adv3 = !v3 || out_ready
  - adv2 = !v2 || adv3
  - adv1 = !v1 || adv2
  - in_ready = adv1.
  - Stage k loads when adv_k. Its valid becomes the upstream valid (in_valid for stage 1).
  - Empty stages are overwritten, so bubbles collapse.
- out_valid = v3. i_out holds its value while out_valid && !out_ready.
- When stage 3 drains with no new data, out_valid drops; i_out keeps its last value.
- Latency: 3 cycles from accept to out_valid with no stall. Throughput: 1 tuple/cycle.
- Capacity is 3 tuples. If all stages are full and out_ready = 0, then in_ready = 0 combinationally.
- Simultaneous drain and fill: a full pipe with out_ready = 1 accepts a new tuple in the same cycle.
- in_ready depends combinationally on out_ready. There is no combinational path from in_valid to out_valid.
- Reset mid-operation clears all valids and acc next edge; in-flight tuples are discarded and no out_valid pulse follows.
- Upstream holds data stable while in_valid && !in_ready. The block does not check this.

Optional Feature:
- Macro: SDP_PIPE_PARITY_EN.
- Defined:
  - Adds output port i_par (1 bit) = even parity (XOR-reduce) of the i_out value.
  - i_par is registered in stage 3 alongside i_out, so the two are always coherent.
  - Reset value 0.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package sdp_pkg holds:
  - constant SDP_W = 8
  - constant SDP_LAT = 3
  - typedef op_t (2-bit {ctl_1, ctl_2}) with names SUB_XOR = 00, SUB_MUL = 01, ADD_XOR = 10, ADD_MAC = 11
  - the reset-value constant for i_out.
- One sub-module is natural: sdp_pipe_stage, a generic valid/data register.
  - Inputs: up_valid, data, down_adv. Outputs: valid, data, adv.
  - Instantiated 3 times; stage 3 adds the accumulator logic outside it.

Test Plan:
- Reset, then a=5, b=3, c=4, ctl_1=1, ctl_2=0, single accept at cycle 0, out_ready=1 -> out_valid=1 at cycle 3 only, i_out=12 (8^4).
- a=5, b=3, c=4, ctl_1=0, ctl_2=1 -> i_out=8. a=3, b=5, c=0, ctl_1=0, ctl_2=0 -> i_out=254 (subtract wrap). a=200, b=100, c=0, ctl_1=1, ctl_2=0 -> i_out=44 (add wrap).
- Accumulate: two back-to-back tuples a=1, b=1, c=3, ctl_1=ctl_2=1 -> i_out=6 at cycle 3, then 12 at cycle 4. A following ADD_XOR tuple does not change acc.
- Backpressure: out_ready=0 while offering 4 consecutive tuples.
  - Expect 3 accepted, then in_ready=0.
  - i_out held stable at the first result.
  - On out_ready=1, results emerge in order, one per cycle, with no loss or duplication.
- Reset asserted with 2 tuples in flight -> next cycle out_valid=0, acc=0, i_out=0. No result appears for the discarded tuples.
- Random 1000-tuple stream with out_ready always 1 -> i_out equals the single-cycle reference model result delayed 3 cycles, every cycle (the equivalence property).
  - With SDP_PIPE_PARITY_EN defined, i_par always equals ^i_out.
